gpio_bank: RTL and testbench

Parametrised multi-pin GPIO peripheral for the picorv32 memory-mapped bus. It replaces the single-pin `gpio` instance with a WIDTH-pin bank: per-pin direction, atomic set/clear, synchronised inputs, and per-pin rising/falling edge interrupts. The interrupts are aggregated into one level `irq` line, which the top level wires into a bit of the CPU `irq` vector. The top level decodes `mem_addr[31:24]` into `valid`; this block decodes only `addr[4:2]`.

---
 rtl/gpio_bank.sv | 111 +++++++++++
 tb/tb_gpio_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// WIDTH-pin GPIO bank for the picorv32 bus: direction, set/clear,
// synchronised inputs and sticky per-pin edge interrupts.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    output logic             ready,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] io_iosel,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic             irq
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      bmask;
    logic [31:0]      wd32;
    logic [31:0]      rmux;
    logic [2:0]       sel;
    logic             access;
    logic             wr;
    logic             rd;
    logic             unused_bits;

    assign sel    = addr[4:2];
    assign access = valid & ~ready;
    assign wr     = access & (|wstrb);
    assign rd     = access & ~(|wstrb);

    assign bmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign wd32  = wdata & bmask;
    assign wm    = bmask[WIDTH-1:0];
    assign wb    = wd32[WIDTH-1:0];
    assign unused_bits = ^{addr[31:5], addr[1:0], wd32, bmask};

    assign sync = chain[SYNC_STAGES-1];
    assign ev   = (sync & ~prev & rise_en) | (~sync & prev & fall_en);
    assign w1c  = (wr && sel == 3'd5) ? wb : '0;

    assign io_out   = out_q;
    assign io_iosel = dir_q;
    assign irq      = |status;

    always_comb begin
        rmux = 32'h0;
        unique case (sel)
            3'd0: rmux = 32'(out_q);
            3'd1: rmux = 32'(dir_q);
            3'd2: rmux = 32'(sync);
            3'd3: rmux = 32'(rise_en);
            3'd4: rmux = 32'(fall_en);
            3'd5: rmux = 32'(status);
            3'd6: rmux = 32'h0;
            3'd7: rmux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready   <= 1'b0;
            rdata   <= 32'h0;
            out_q   <= '0;
            dir_q   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            prev    <= '0;
            chain   <= '0;
        end else begin
            ready    <= access;
            rdata    <= rd ? rmux : 32'h0;
            chain[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev   <= sync;
            // an edge landing with a W1C of the same bit keeps the bit set
            status <= (status & ~w1c) | ev;
            if (wr) begin
                unique case (sel)
                    3'd0: out_q   <= (out_q & ~wm) | wb;
                    3'd1: dir_q   <= (dir_q & ~wm) | wb;
                    3'd2: ;
                    3'd3: rise_en <= (rise_en & ~wm) | wb;
                    3'd4: fall_en <= (fall_en & ~wm) | wb;
                    3'd5: ;
                    3'd6: out_q   <= out_q | wb;
                    3'd7: out_q   <= out_q & ~wb;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: register table plus edge,
// W1C-collision, handshake and reset-mid-access sequences.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  io_iosel;
    logic [7:0]  io_in;
    logic [7:0]  io_out;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] wd;
        logic [3:0]  s;
        logic [31:0] rd;
        logic [7:0]  out;
        logic [7:0]  sel;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata),
        .io_iosel(io_iosel), .io_in(io_in), .io_out(io_out), .irq(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [4:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [31:0] exp,
                       input string nm);
        int n;
        logic [31:0] e;
        if (s == 4'h0) exp_q.push_back(exp);
        @(negedge clk);
        valid = 1'b1;
        addr  = {27'h0, a};
        wdata = wd;
        wstrb = s;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 8);
        chk({nm, " latency"}, 32'(n), 32'd1);
        if (s == 4'h0) begin
            e = exp_q.pop_front();
            if (ready) chk(nm, rdata, e);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " ready drop"}, {31'h0, ready}, 32'h0);
    endtask

    task automatic add(input logic [4:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [31:0] rd,
                       input logic [7:0] out, input logic [7:0] sel,
                       input string nm);
        vec_t v;
        v.a = a; v.wd = wd; v.s = s; v.rd = rd;
        v.out = out; v.sel = sel; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        int back2back;
        logic last;

        add(5'h00, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd OUT rst");
        add(5'h04, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd DIR rst");
        add(5'h08, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd IN rst");
        add(5'h0C, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd RISE rst");
        add(5'h10, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd FALL rst");
        add(5'h14, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd STAT rst");
        add(5'h18, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd SET rst");
        add(5'h1C, 0, 4'h0, 32'h0, 8'h00, 8'h00, "rd CLR rst");
        add(5'h04, 32'hFF, 4'hF, 0, 8'h00, 8'hFF, "wr DIR");
        add(5'h00, 32'hA5, 4'hF, 0, 8'hA5, 8'hFF, "wr OUT");
        add(5'h18, 32'h02, 4'hF, 0, 8'hA7, 8'hFF, "wr SET");
        add(5'h1C, 32'h80, 4'hF, 0, 8'h27, 8'hFF, "wr CLR");
        add(5'h00, 0, 4'h0, 32'h27, 8'h27, 8'hFF, "rd OUT 27");
        add(5'h18, 0, 4'h0, 32'h0, 8'h27, 8'hFF, "rd SET");
        add(5'h1C, 0, 4'h0, 32'h0, 8'h27, 8'hFF, "rd CLR");
        add(5'h00, 32'hFFFFFF00, 4'hE, 0, 8'h27, 8'hFF, "wr OUT hi");
        add(5'h00, 32'h11223344, 4'h1, 0, 8'h44, 8'hFF, "wr OUT b0");
        add(5'h00, 32'h11223344, 4'h2, 0, 8'h44, 8'hFF, "wr OUT b1");
        add(5'h18, 32'h000000FF, 4'h2, 0, 8'h44, 8'hFF, "SET nostrb");
        add(5'h1C, 32'h000000FF, 4'h1, 0, 8'h00, 8'hFF, "CLR b0");
        add(5'h04, 32'hFFFFFF3C, 4'hF, 0, 8'h00, 8'h3C, "wr DIR all");
        add(5'h04, 0, 4'h0, 32'h3C, 8'h00, 8'h3C, "rd DIR 3C");
        add(5'h14, 32'hFFFFFFFF, 4'hF, 0, 8'h00, 8'h3C, "w1c none");
        add(5'h14, 0, 4'h0, 32'h0, 8'h00, 8'h3C, "rd STAT 0");
        add(5'h08, 0, 4'h0, 32'h0, 8'h00, 8'h3C, "rd IN 0");
        add(5'h0C, 32'hFFFFFF01, 4'hF, 0, 8'h00, 8'h3C, "wr RISE");
        add(5'h0C, 0, 4'h0, 32'h01, 8'h00, 8'h3C, "rd RISE");
        add(5'h10, 32'h04, 4'hF, 0, 8'h00, 8'h3C, "wr FALL");
        add(5'h10, 0, 4'h0, 32'h04, 8'h00, 8'h3C, "rd FALL");

        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        io_in  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", {31'h0, ready}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst irq", {31'h0, irq}, 32'h0);
        chk("rst out", {24'h0, io_out}, 32'h0);
        chk("rst iosel", {24'h0, io_iosel}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].a, tbl[i].wd, tbl[i].s, tbl[i].rd, tbl[i].nm);
            chk({tbl[i].nm, " io_out"}, {24'h0, io_out}, {24'h0, tbl[i].out});
            chk({tbl[i].nm, " iosel"}, {24'h0, io_iosel}, {24'h0, tbl[i].sel});
            chk({tbl[i].nm, " irq"}, {31'h0, irq}, 32'h0);
        end

        // rising edge on pin 0: IN after k+1, STATUS/irq after k+2
        @(negedge clk);
        io_in = 8'h01;
        @(posedge clk); #1;
        chk("rise irq k", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise irq k+1", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("rise irq k+2", {31'h0, irq}, 32'h1);
        bus(5'h08, 0, 4'h0, 32'h01, "rd IN 01");
        bus(5'h14, 0, 4'h0, 32'h01, "rd STAT 01");
        @(negedge clk);
        io_in = 8'h00;
        repeat (4) @(posedge clk);
        bus(5'h14, 0, 4'h0, 32'h01, "fall pin0 ignored");
        bus(5'h14, 32'h01, 4'hF, 0, "w1c pin0");
        chk("w1c pin0 irq", {31'h0, irq}, 32'h0);

        // falling edge on pin 2 with W1C landing on the same edge
        @(negedge clk);
        io_in = 8'h04;
        repeat (5) @(posedge clk);
        bus(5'h14, 0, 4'h0, 32'h0, "rise pin2 ignored");
        @(negedge clk);
        io_in = 8'h00;
        repeat (5) @(posedge clk);
        bus(5'h14, 0, 4'h0, 32'h04, "fall pin2");
        @(negedge clk);
        io_in = 8'h04;
        repeat (5) @(posedge clk);
        @(negedge clk);
        io_in = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        valid = 1'b1;
        addr  = 32'h14;
        wdata = 32'h04;
        wstrb = 4'hF;
        @(posedge clk);
        #1;
        chk("collide ready", {31'h0, ready}, 32'h1);
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("collide irq", {31'h0, irq}, 32'h1);
        bus(5'h14, 0, 4'h0, 32'h04, "collide set wins");
        bus(5'h14, 32'h04, 4'hF, 0, "w1c pin2");
        chk("w1c pin2 irq", {31'h0, irq}, 32'h0);
        bus(5'h14, 0, 4'h0, 32'h0, "rd STAT cleared");

        // held valid re-acknowledges every other cycle
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h10;
        wstrb = 4'h0;
        pulses = 0;
        back2back = 0;
        last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
            if (ready && last) back2back++;
            last = ready;
        end
        valid = 1'b0;
        chk("held pulses", 32'(pulses), 32'd4);
        chk("held b2b", 32'(back2back), 32'd0);
        @(posedge clk);

        // reset landing on an access start, pin 0 high through reset
        bus(5'h00, 32'h5A, 4'hF, 0, "wr OUT 5A");
        chk("pre-rst out", {24'h0, io_out}, 32'h5A);
        @(negedge clk);
        io_in  = 8'h01;
        valid  = 1'b1;
        addr   = 32'h00;
        wdata  = 32'hFF;
        wstrb  = 4'hF;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst ready", {31'h0, ready}, 32'h0);
        chk("midrst out", {24'h0, io_out}, 32'h0);
        chk("midrst iosel", {24'h0, io_iosel}, 32'h0);
        valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post-rst irq", {31'h0, irq}, 32'h0);
        bus(5'h14, 0, 4'h0, 32'h0, "post-rst STAT");
        bus(5'h00, 0, 4'h0, 32'h0, "post-rst OUT");
        bus(5'h08, 0, 4'h0, 32'h01, "post-rst IN");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
